counter_updown: RTL

//  Parametrised up/down counter with bounded range [MIN_VALUE, MAX_VALUE].

---
 rtl/counter_updown_pkg.sv | 12 +
 rtl/counter_updown.sv | 114 +++++++++++
 2 files changed

// File: rtl/counter_updown_pkg.sv
// Shared definitions for bounded counters and the timing generators built on them.
package counter_updown_pkg;

   localparam int CNT_MODE_WRAP = 0;
   localparam int CNT_MODE_SAT  = 1;

   // Bits needed to hold 0..max_value; never narrower than one bit.
   function automatic int cnt_width(input int max_value);
      return (max_value < 1) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/counter_updown.sv
// Bounded up/down counter with programmable step, wrap or saturate at the bounds,
// sync clear/load and registered wrap/sat pulses for cascading.
module counter_updown
   import counter_updown_pkg::*;
#(
   parameter int MIN_VALUE   = 0,
   parameter int MAX_VALUE   = 16,
   parameter int STEP        = 1,
   parameter int SATURATE    = CNT_MODE_WRAP,
   parameter int RESET_VALUE = MIN_VALUE,
   parameter int WIDTH       = cnt_width(MAX_VALUE)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   input  logic             up,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap,
   output logic             sat
);

   generate
      if (MAX_VALUE < MIN_VALUE) begin : g_err_bounds
         $error("counter_updown: MAX_VALUE must be >= MIN_VALUE");
      end
      if (MIN_VALUE < 0 || (64'(MAX_VALUE) >> WIDTH) != 64'd0) begin : g_err_width
         $error("counter_updown: bounds do not fit in WIDTH bits");
      end
      if (RESET_VALUE < MIN_VALUE || RESET_VALUE > MAX_VALUE) begin : g_err_reset
         $error("counter_updown: RESET_VALUE out of range");
      end
      if (STEP < 1 || STEP > (MAX_VALUE - MIN_VALUE + 1)) begin : g_err_step
         $error("counter_updown: STEP must be in 1..(MAX_VALUE-MIN_VALUE+1)");
      end
   endgenerate

   // Two guard bits keep count+STEP and MIN+STEP free of overflow.
   localparam int AW = WIDTH + 2;

   localparam logic [AW-1:0]    MIN_E      = AW'(MIN_VALUE);
   localparam logic [AW-1:0]    MAX_E      = AW'(MAX_VALUE);
   localparam logic [AW-1:0]    STEP_E     = AW'(STEP);
   localparam logic [AW-1:0]    MIN_STEP_E = AW'(MIN_VALUE + STEP);
   localparam logic [WIDTH-1:0] MIN_W      = WIDTH'(MIN_VALUE);
   localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_VALUE);
   localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] RST_W      = WIDTH'(RESET_VALUE);
   localparam bit               SAT_MODE   = (SATURATE == CNT_MODE_SAT);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             sat_q, sat_d;
   logic [AW-1:0]    cnt_e, lv_e, up_sum;

   assign cnt_e  = {2'b00, count_q};
   assign lv_e   = {2'b00, load_val};
   assign up_sum = cnt_e + STEP_E;

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      sat_d   = 1'b0;
      if (clear) begin
         count_d = RST_W;
      end else if (load) begin
         if (lv_e < MIN_E)      count_d = MIN_W;
         else if (lv_e > MAX_E) count_d = MAX_W;
         else                   count_d = load_val;
      end else if (enable) begin
         if (up) begin
            if (up_sum > MAX_E) begin
               // Out-of-range step: saturate holds the bound, wrap restarts exactly at MIN.
               count_d = SAT_MODE ? MAX_W : MIN_W;
               sat_d   = SAT_MODE;
               wrap_d  = !SAT_MODE;
            end else begin
               count_d = up_sum[WIDTH-1:0];
            end
         end else begin
            if (cnt_e < MIN_STEP_E) begin
               count_d = SAT_MODE ? MIN_W : MAX_W;
               sat_d   = SAT_MODE;
               wrap_d  = !SAT_MODE;
            end else begin
               count_d = count_q - STEP_W;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= RST_W;
         wrap_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         sat_q   <= sat_d;
      end
   end

   assign count  = count_q;
   assign wrap   = wrap_q;
   assign sat    = sat_q;
   assign at_max = (count_q == MAX_W);
   assign at_min = (count_q == MIN_W);

endmodule
